// File: rtl/control_pkg.sv
// Shared encodings for the ARMv4 single-cycle control unit: ALU commands,
// instruction classes, condition codes and the Control word bit layout.
package control_pkg;

    localparam logic [3:0] ALU_ADD = 4'b0100;
    localparam logic [3:0] ALU_SUB = 4'b0010;
    localparam logic [3:0] ALU_AND = 4'b0000;
    localparam logic [3:0] ALU_ORR = 4'b1100;

    localparam logic [3:0] CMD_AND = 4'b0000;
    localparam logic [3:0] CMD_SUB = 4'b0010;
    localparam logic [3:0] CMD_ADD = 4'b0100;
    localparam logic [3:0] CMD_CMP = 4'b1010;
    localparam logic [3:0] CMD_ORR = 4'b1100;

    typedef enum logic [1:0] {
        OP_DP    = 2'b00,
        OP_MEM   = 2'b01,
        OP_BR    = 2'b10,
        OP_UNDEF = 2'b11
    } op_e;

    typedef enum logic [3:0] {
        COND_EQ = 4'h0, COND_NE = 4'h1, COND_CS = 4'h2, COND_CC = 4'h3,
        COND_MI = 4'h4, COND_PL = 4'h5, COND_VS = 4'h6, COND_VC = 4'h7,
        COND_HI = 4'h8, COND_LS = 4'h9, COND_GE = 4'hA, COND_LT = 4'hB,
        COND_GT = 4'hC, COND_LE = 4'hD, COND_AL = 4'hE, COND_NV = 4'hF
    } cond_e;

    localparam logic [1:0] IMM_DP  = 2'b00;
    localparam logic [1:0] IMM_MEM = 2'b01;
    localparam logic [1:0] IMM_BR  = 2'b10;

    localparam logic [1:0] REGSRC_DP  = 2'b00;
    localparam logic [1:0] REGSRC_BR  = 2'b01;
    localparam logic [1:0] REGSRC_STR = 2'b10;

    localparam int CTL_PCSRC      = 12;
    localparam int CTL_MEMTOREG   = 11;
    localparam int CTL_MEMWRITE   = 10;
    localparam int CTL_ALUCTL_LSB = 6;
    localparam int CTL_ALUSRC     = 5;
    localparam int CTL_IMMSRC_LSB = 3;
    localparam int CTL_REGWRITE   = 2;
    localparam int CTL_REGSRC_LSB = 0;

    // NV is treated as never rather than the ARMv5 unconditional space.
    function automatic logic condPassed(input logic [3:0] cond, input logic [3:0] nzcv);
        logic n, z, c, v, pass;
        {n, z, c, v} = nzcv;
        pass = 1'b0;
        case (cond_e'(cond))
            COND_EQ: pass = z;
            COND_NE: pass = ~z;
            COND_CS: pass = c;
            COND_CC: pass = ~c;
            COND_MI: pass = n;
            COND_PL: pass = ~n;
            COND_VS: pass = v;
            COND_VC: pass = ~v;
            COND_HI: pass = c & ~z;
            COND_LS: pass = ~c | z;
            COND_GE: pass = (n == v);
            COND_LT: pass = (n != v);
            COND_GT: pass = ~z & (n == v);
            COND_LE: pass = z | (n != v);
            COND_AL: pass = 1'b1;
            COND_NV: pass = 1'b0;
        endcase
        return pass;
    endfunction

endpackage

// File: rtl/control_unit_if.sv
// Control/InstrControl/ALUFlags link between the datapath (master) and the
// control unit (slave).
interface control_unit_if #(
    parameter int CNT_W = 16
);
    logic [19:0]      InstrControl;
    logic [3:0]       ALUFlags;
    logic [12:0]      Control;
    logic [3:0]       Flags;
    logic             CondEx;
    logic             Undef;
    logic [CNT_W-1:0] RetiredCount;

    modport master (
        output InstrControl, ALUFlags,
        input  Control, Flags, CondEx, Undef, RetiredCount
    );

    modport slave (
        input  InstrControl, ALUFlags,
        output Control, Flags, CondEx, Undef, RetiredCount
    );
endinterface

// File: rtl/control_unit_cond_logic.sv
// Architectural NZCV register with condition evaluation; the condition always
// looks at the registered flags, so an S instruction's result is seen next cycle.
module cond_logic
    import control_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] cond_i,
    input  logic       allow_i,
    input  logic       flagWrite_i,
    input  logic       flagAll_i,
    input  logic [3:0] aluFlags_i,
    output logic [3:0] flags_o,
    output logic       condEx_o
);

    logic [3:0] flags_q, flags_d;

    assign condEx_o = allow_i & condPassed(cond_i, flags_q);
    assign flags_o  = flags_q;

    // Logical operations leave C and V untouched.
    always_comb begin
        flags_d = flags_q;
        if (condEx_o && flagWrite_i) begin
            if (flagAll_i) flags_d = aluFlags_i;
            else           flags_d[3:2] = aluFlags_i[3:2];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) flags_q <= 4'b0000;
        else     flags_q <= flags_d;
    end

endmodule

// File: rtl/control_unit.sv
// Single-cycle ARMv4 control unit: combinational decode of Instr[31:12],
// condition gating of all state-changing enables, boot window and retire counter.
module control_unit
    import control_pkg::*;
#(
    parameter int BOOT_CYCLES = 1,
    parameter int CNT_W       = 16
) (
    input logic           clk,
    input logic           rst,
    control_unit_if.slave bus
);

    localparam int BOOT_W = (BOOT_CYCLES > 1) ? $clog2(BOOT_CYCLES + 1) : 1;

    logic [3:0]  cond, cmd, rd;
    logic [5:0]  funct;
    op_e         op;

    logic        pcSrcDec, memtoReg, memWriteDec, aluSrc, regWriteDec, undef, flagAll;
    logic [3:0]  aluCtl;
    logic [1:0]  immSrc, regSrc;

    logic        condEx, allow, booting;
    logic [3:0]  flags;
    logic [12:0] ctl;

    logic [BOOT_W-1:0] bootCnt_q, bootCnt_d;
    logic [CNT_W-1:0]  retired_q, retired_d;

    assign cond  = bus.InstrControl[19:16];
    assign op    = op_e'(bus.InstrControl[15:14]);
    assign funct = bus.InstrControl[13:8];
    assign rd    = bus.InstrControl[3:0];
    assign cmd   = funct[4:1];

    always_comb begin
        pcSrcDec    = 1'b0;
        memtoReg    = 1'b0;
        memWriteDec = 1'b0;
        aluCtl      = ALU_AND;
        aluSrc      = 1'b0;
        immSrc      = IMM_DP;
        regWriteDec = 1'b0;
        regSrc      = REGSRC_DP;
        undef       = 1'b0;
        flagAll     = 1'b0;
        case (op)
            OP_DP: begin
                aluSrc      = funct[5];
                regWriteDec = (cmd != CMD_CMP);
                flagAll     = (cmd == CMD_ADD) || (cmd == CMD_SUB) || (cmd == CMD_CMP);
                case (cmd)
                    CMD_ADD:          aluCtl = ALU_ADD;
                    CMD_SUB, CMD_CMP: aluCtl = ALU_SUB;
                    CMD_AND:          aluCtl = ALU_AND;
                    CMD_ORR:          aluCtl = ALU_ORR;
                    default:          aluCtl = ALU_ADD;
                endcase
            end
            OP_MEM: begin
                aluSrc = 1'b1;
                immSrc = IMM_MEM;
                aluCtl = ALU_ADD;
                if (funct[0]) begin
                    regWriteDec = 1'b1;
                    memtoReg    = 1'b1;
                end else begin
                    memWriteDec = 1'b1;
                    regSrc      = REGSRC_STR;
                end
            end
            OP_BR: begin
                pcSrcDec = 1'b1;
                aluSrc   = 1'b1;
                immSrc   = IMM_BR;
                regSrc   = REGSRC_BR;
                aluCtl   = ALU_ADD;
            end
            OP_UNDEF: undef = 1'b1;
        endcase
        // Writing R15 is a jump, whatever the instruction class.
        if (regWriteDec && rd == 4'hF) pcSrcDec = 1'b1;
    end

    assign booting = (bootCnt_q != '0);
    assign allow   = ~rst & ~booting;

    cond_logic u_cond (
        .clk        (clk),
        .rst        (rst),
        .cond_i     (cond),
        .allow_i    (allow),
        .flagWrite_i((op == OP_DP) && funct[0]),
        .flagAll_i  (flagAll),
        .aluFlags_i (bus.ALUFlags),
        .flags_o    (flags),
        .condEx_o   (condEx)
    );

    always_comb begin
        ctl = '0;
        ctl[CTL_PCSRC]                = pcSrcDec & condEx;
        ctl[CTL_MEMTOREG]             = memtoReg;
        ctl[CTL_MEMWRITE]             = memWriteDec & condEx;
        ctl[CTL_ALUCTL_LSB +: 4]      = aluCtl;
        ctl[CTL_ALUSRC]               = aluSrc;
        ctl[CTL_IMMSRC_LSB +: 2]      = immSrc;
        ctl[CTL_REGWRITE]             = regWriteDec & condEx;
        ctl[CTL_REGSRC_LSB +: 2]      = regSrc;
    end

    always_comb begin
        bootCnt_d = booting ? bootCnt_q - 1'b1 : bootCnt_q;
        retired_d = (condEx && !undef) ? retired_q + 1'b1 : retired_q;
    end

    // Reset reloads the boot window so the ROM latency is covered again.
    always_ff @(posedge clk) begin
        if (rst) begin
            bootCnt_q <= BOOT_W'(BOOT_CYCLES);
            retired_q <= '0;
        end else begin
            bootCnt_q <= bootCnt_d;
            retired_q <= retired_d;
        end
    end

    assign bus.Control      = ctl;
    assign bus.Flags        = flags;
    assign bus.CondEx       = condEx;
    assign bus.Undef        = undef;
    assign bus.RetiredCount = retired_q;

endmodule
